// File: rtl/denise_clut_ham.sv
// Banked 24-bit colour lookup table with a two-stage read pipeline, bitplane XOR
// and normal / EHB / HAM6 / HAM8 output modes sharing one HAM hold register.
module denise_clut_ham #(
    parameter int BANKS  = 8,
    parameter bit XOR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [11:0] data_in,
    input  logic [2:0]  bank,
    input  logic        loct,
    input  logic [7:0]  select,
    input  logic [7:0]  bplxor,
    input  logic [1:0]  mode,
    input  logic        blank,
    output logic [23:0] rgb
);
    localparam int AW    = 5 + $clog2(BANKS);
    localparam int DEPTH = 32 * BANKS;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_EHB    = 2'b01,
        MODE_HAM6   = 2'b10,
        MODE_HAM8   = 2'b11
    } mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    logic [11:0] hi_mem [DEPTH];
    logic [11:0] lo_mem [DEPTH];

    logic          wr_en;
    logic [7:0]    wr_addr_full;
    logic [AW-1:0] wr_addr;
    logic [11:0]   color0_hi, color0_lo;

    logic [7:0]    idx;
    logic [7:0]    rd_addr_full;
    logic [AW-1:0] rd_addr;

    logic [11:0]   rd_hi, rd_lo;
    logic [7:0]    idx_q;
    mode_t         mode_q;
    logic          blank_q;

    rgb_t          rgb_q, rgb_nxt, c, c0, h;
    logic          hold_c0;

    assign wr_addr_full = {bank, reg_address_in[5:1]};
    assign wr_addr      = wr_addr_full[AW-1:0];
    assign wr_en        = clk7_en && (reg_address_in[8:6] == 3'b110)
                          && (32'(bank) < 32'(BANKS));

    // Write side. Low word is always written; loct protects the high word.
    // NOTE: the colour RAM has no reset; clearing it would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lo_mem[wr_addr] <= data_in;
            if (!loct)
                hi_mem[wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            color0_hi <= '0;
            color0_lo <= '0;
        end else if (wr_en && wr_addr_full == 8'h00) begin
            color0_lo <= data_in;
            if (!loct)
                color0_hi <= data_in;
        end
    end

    assign idx = XOR_EN ? (select ^ bplxor) : select;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_addr_full = idx;
        case (mode_t'(mode))
            MODE_NORMAL: rd_addr_full = idx;
            MODE_EHB:    rd_addr_full = {3'b000, idx[4:0]};
            MODE_HAM6:   rd_addr_full = {4'b0000, idx[3:0]};
            MODE_HAM8:   rd_addr_full = {2'b00, idx[7:2]};
        endcase
    end
    assign rd_addr = rd_addr_full[AW-1:0];

    // Stage 1: registered RAM read; a same-cycle write to the entry is seen next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_hi   <= '0;
            rd_lo   <= '0;
            idx_q   <= '0;
            mode_q  <= MODE_NORMAL;
            blank_q <= 1'b0;
        end else begin
            rd_hi   <= hi_mem[rd_addr];
            rd_lo   <= lo_mem[rd_addr];
            idx_q   <= idx;
            mode_q  <= mode_t'(mode);
            blank_q <= blank;
        end
    end

    assign c  = '{r: {rd_hi[11:8], rd_lo[11:8]},
                  g: {rd_hi[7:4],  rd_lo[7:4]},
                  b: {rd_hi[3:0],  rd_lo[3:0]}};
    assign c0 = '{r: {color0_hi[11:8], color0_lo[11:8]},
                  g: {color0_hi[7:4],  color0_lo[7:4]},
                  b: {color0_hi[3:0],  color0_lo[3:0]}};
    // After a blanked pixel the HAM hold restarts from the background colour.
    assign h  = hold_c0 ? c0 : rgb_q;

    always_comb begin
        rgb_nxt = c;
        if (blank_q) begin
            rgb_nxt = '0;
        end else begin
            case (mode_q)
                MODE_NORMAL: rgb_nxt = c;
                MODE_EHB: begin
                    if (idx_q[5])
                        rgb_nxt = '{r: {1'b0, c.r[7:1]},
                                    g: {1'b0, c.g[7:1]},
                                    b: {1'b0, c.b[7:1]}};
                end
                MODE_HAM6: begin
                    rgb_nxt = h;
                    case (idx_q[5:4])
                        2'b00: rgb_nxt   = c;
                        2'b01: rgb_nxt.b = {idx_q[3:0], idx_q[3:0]};
                        2'b10: rgb_nxt.r = {idx_q[3:0], idx_q[3:0]};
                        2'b11: rgb_nxt.g = {idx_q[3:0], idx_q[3:0]};
                    endcase
                end
                MODE_HAM8: begin
                    rgb_nxt = h;
                    case (idx_q[1:0])
                        2'b00: rgb_nxt   = c;
                        2'b01: rgb_nxt.b = {idx_q[7:2], h.b[1:0]};
                        2'b10: rgb_nxt.r = {idx_q[7:2], h.r[1:0]};
                        2'b11: rgb_nxt.g = {idx_q[7:2], h.g[1:0]};
                    endcase
                end
            endcase
        end
    end

    // Stage 2: output register doubles as the HAM hold value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q   <= '0;
            hold_c0 <= 1'b0;
        end else begin
            rgb_q   <= rgb_nxt;
            hold_c0 <= blank_q;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: tb/tb_denise_clut_ham.sv
// Directed bench for denise_clut_ham: writes, modes, HAM hold, banking, XOR,
// read/write collision and mid-stream reset, with hand-computed colours.
module tb_denise_clut_ham;
    localparam logic [1:0] M_NORM = 2'b00;
    localparam logic [1:0] M_EHB  = 2'b01;
    localparam logic [1:0] M_HAM6 = 2'b10;
    localparam logic [1:0] M_HAM8 = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk7_en = 1'b0;
    logic [8:1]  reg_address_in = '0;
    logic [11:0] data_in = '0;
    logic [2:0]  bank = '0;
    logic        loct = 1'b0;
    logic [7:0]  select = '0;
    logic [7:0]  bplxor = '0;
    logic [1:0]  mode = M_NORM;
    logic        blank = 1'b0;
    logic [23:0] rgb, rgb2;

    int total = 0;
    int bad   = 0;

    logic [7:0]  seq_sel  [8];
    logic [1:0]  seq_mode [8];
    logic        seq_blk  [8];
    logic [23:0] seq_exp  [8];

    always #18 clk = ~clk;

    denise_clut_ham dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en), .reg_address_in(reg_address_in),
        .data_in(data_in), .bank(bank), .loct(loct), .select(select), .bplxor(bplxor),
        .mode(mode), .blank(blank), .rgb(rgb)
    );

    denise_clut_ham #(.BANKS(2), .XOR_EN(1'b0)) dut_b2 (
        .clk(clk), .reset(reset), .clk7_en(clk7_en), .reg_address_in(reg_address_in),
        .data_in(data_in), .bank(bank), .loct(loct), .select(select), .bplxor(bplxor),
        .mode(mode), .blank(blank), .rgb(rgb2)
    );

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [11:0] d,
                      input logic lo, input logic [2:0] bk);
        logic [15:0] a;
        a = addr;
        @(negedge clk);
        clk7_en        = 1'b1;
        reg_address_in = a[8:1];
        data_in        = d;
        loct           = lo;
        bank           = bk;
        @(negedge clk);
        clk7_en = 1'b0;
        loct    = 1'b0;
        bank    = 3'd0;
    endtask

    // Drive one pixel and wait until its colour is on rgb.
    task automatic pix(input logic [7:0] sel, input logic [1:0] md, input logic blk);
        @(negedge clk);
        select = sel;
        mode   = md;
        blank  = blk;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_px(input int i, input logic [7:0] sel, input logic [1:0] md,
                          input logic blk, input logic [23:0] exp);
        seq_sel[i]  = sel;
        seq_mode[i] = md;
        seq_blk[i]  = blk;
        seq_exp[i]  = exp;
    endtask

    // Back-to-back pixels; each result is checked two clocks after it was driven.
    task automatic run_seq(input int n, input string base);
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2)
                check($sformatf("%s%0d", base, i - 2), rgb, seq_exp[i-2]);
            if (i < n) begin
                select = seq_sel[i];
                mode   = seq_mode[i];
                blank  = seq_blk[i];
            end
        end
        blank = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rgb", rgb, 24'h000000);
        check("reset_rgb_b2", rgb2, 24'h000000);
        reset = 1'b0;

        // Full and low-only writes
        wr(16'h180, 12'hF80, 1'b0, 3'd0);
        pix(8'h00, M_NORM, 1'b0);
        check("wr_full", rgb, 24'hFF8800);
        wr(16'h180, 12'h123, 1'b1, 3'd0);
        pix(8'h00, M_NORM, 1'b0);
        check("wr_loct", rgb, 24'hF18203);

        // Extra half-brite
        wr(16'h182, 12'hFFF, 1'b0, 3'd0);
        pix(8'h01, M_EHB, 1'b0);
        check("ehb_01", rgb, 24'hFFFFFF);
        pix(8'h21, M_EHB, 1'b0);
        check("ehb_21", rgb, 24'h7F7F7F);
        pix(8'hE1, M_EHB, 1'b0);
        check("ehb_e1", rgb, 24'h7F7F7F);

        // HAM6 from a black background
        wr(16'h180, 12'h000, 1'b0, 3'd0);
        set_px(0, 8'h00, M_HAM6, 1'b1, 24'h000000);
        set_px(1, 8'h00, M_HAM6, 1'b0, 24'h000000);
        set_px(2, 8'h1A, M_HAM6, 1'b0, 24'h0000AA);
        set_px(3, 8'h25, M_HAM6, 1'b0, 24'h5500AA);
        set_px(4, 8'h3C, M_HAM6, 1'b0, 24'h55CCAA);
        run_seq(5, "ham6_");

        // HAM8, including hold reload from color0 after blank
        wr(16'h180, 12'hFFF, 1'b0, 3'd0);
        set_px(0, 8'h00, M_HAM8, 1'b0, 24'hFFFFFF);
        set_px(1, 8'h01, M_HAM8, 1'b0, 24'hFFFF03);
        set_px(2, 8'h00, M_HAM8, 1'b1, 24'h000000);
        set_px(3, 8'h02, M_HAM8, 1'b0, 24'h03FFFF);
        run_seq(4, "ham8_");

        // Banked write; a two-bank instance must ignore bank 2
        wr(16'h180, 12'h0F0, 1'b0, 3'd2);
        pix(8'h40, M_NORM, 1'b0);
        check("bank2", rgb, 24'h00FF00);
        check("bank2_ignored", rgb2, 24'hFFFFFF);

        // Bitplane XOR (second instance has XOR disabled)
        wr(16'h182, 12'h00F, 1'b0, 3'd0);
        bplxor = 8'h01;
        pix(8'h00, M_NORM, 1'b0);
        check("xor_on", rgb, 24'h0000FF);
        check("xor_off", rgb2, 24'hFFFFFF);
        bplxor = 8'h00;

        // Same-cycle write and read of entry 5
        wr(16'h18A, 12'h111, 1'b0, 3'd0);
        @(negedge clk);
        clk7_en        = 1'b1;
        reg_address_in = 8'hC5;
        data_in        = 12'h222;
        select         = 8'h05;
        mode           = M_NORM;
        blank          = 1'b0;
        @(negedge clk);
        clk7_en = 1'b0;
        @(negedge clk);
        check("coll_old", rgb, 24'h111111);
        @(negedge clk);
        check("coll_new", rgb, 24'h222222);

        // Reset in the middle of a stream
        pix(8'h00, M_NORM, 1'b0);
        check("pre_rst", rgb, 24'hFFFFFF);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid", rgb, 24'h000000);
        reset = 1'b0;
        @(negedge clk);
        check("rst_clean", rgb, 24'h000000);
        set_px(0, 8'h00, M_HAM6, 1'b1, 24'h000000);
        set_px(1, 8'h1A, M_HAM6, 1'b0, 24'h0000AA);
        run_seq(2, "rst_c0_");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
